lut_arbiter: RTL

- Shares one clocked trig LUT (ports op_selector, clk, angle[31:0], value[31:0]) among NUM_REQ requesters.
- Round-robin grant; at most one LUT lookup issued per cycle.
- Tracks in-flight lookups through the LUT read latency and returns each value tagged with the requester ID.
- Sits between the processing lanes and the single LUT instance.

---
 rtl/lut_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/lut_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lut_pkg.sv
// Shared types and constants for the trig-LUT arbiter.
// Provides the LUT data widths, the in-flight tag carried alongside each
// lookup, and the op_selector encoding seen by the LUT.
package lut_pkg;

    localparam int unsigned LUT_ANGLE_W  = 32;
    localparam int unsigned LUT_VALUE_W  = 32;
    // Tag ID sized for the largest supported requester count (8).
    localparam int unsigned LUT_ID_W_MAX = 3;

    typedef struct packed {
        logic                    vld;
        logic [LUT_ID_W_MAX-1:0] id;
    } lut_tag_t;

    typedef enum logic {
        LUT_OP_0 = 1'b0,
        LUT_OP_1 = 1'b1
    } lut_op_e;

endpackage : lut_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable by any shared unit.
// Ports:
//   req     - per-requester request vector
//   ptr     - index with highest priority this cycle
//   gnt     - one-hot grant (all-zero when no request)
//   gnt_id  - index of the granted requester
//   any_gnt - a grant is issued this cycle
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any_gnt
);

    // Scan from ptr upward, wrapping modulo NUM_REQ; first request wins.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(ptr) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!any_gnt && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                gnt_id     = idx_w;
                any_gnt    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/lut_arbiter.sv
// Shares one clocked trig LUT among NUM_REQ requesters.
// Round-robin grant, at most one lookup per cycle; each lookup is tracked
// through the LUT latency and its value returned tagged with the requester.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req_valid/req_op/req_angle - per-requester lookup requests
//   req_ready                  - one-hot grant (combinational)
//   lut_op_selector/lut_angle  - registered LUT inputs
//   lut_value                  - LUT output
//   resp_valid/resp_id/resp_value - tagged lookup result
//   busy                       - any lookup in flight or being returned
// Optional: define LUT_ARBITER_STATS_EN to add saturating grant_cnt and
// conflict_cnt outputs.
module lut_arbiter
    import lut_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LUT_LAT = 1,
    parameter int unsigned ID_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_op,
    input  logic [NUM_REQ*LUT_ANGLE_W-1:0]  req_angle,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            lut_op_selector,
    output logic [LUT_ANGLE_W-1:0]          lut_angle,
    input  logic [LUT_VALUE_W-1:0]          lut_value,
    output logic                            resp_valid,
    output logic [ID_W-1:0]                 resp_id,
    output logic [LUT_VALUE_W-1:0]          resp_value,
    output logic                            busy
`ifdef LUT_ARBITER_STATS_EN
    ,
    output logic [15:0]                     grant_cnt,
    output logic [15:0]                     conflict_cnt
`endif
);

    // The LUT output settles LUT_LAT edges after its inputs are registered
    // and is captured one edge later, so tags travel LUT_LAT+1 stages.
    localparam int unsigned PIPE_D = LUT_LAT + 1;

    logic [NUM_REQ-1:0]     gnt;
    logic [ID_W-1:0]        gnt_id;
    logic                   any_gnt;
    logic                   sel_op;
    logic [LUT_ANGLE_W-1:0] sel_angle;

    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    lut_op_e                lut_op_q, lut_op_d;
    logic [LUT_ANGLE_W-1:0] lut_angle_q, lut_angle_d;
    lut_tag_t               tag_q [PIPE_D];
    lut_tag_t               tag_d [PIPE_D];
    logic                   resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic [LUT_VALUE_W-1:0] resp_value_q, resp_value_d;
    logic                   unused_tag_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_gnt (any_gnt)
    );

    // One-hot AND-OR mux of the winner's op and angle.
    always_comb begin
        sel_op    = 1'b0;
        sel_angle = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_op    = sel_op | (req_op[i] & gnt[i]);
            sel_angle = sel_angle |
                        (req_angle[i*LUT_ANGLE_W +: LUT_ANGLE_W] & {LUT_ANGLE_W{gnt[i]}});
        end
    end

    // Next-state: LUT inputs, round-robin pointer, tag pipeline, response.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lut_op_d     = lut_op_q;
        lut_angle_d  = lut_angle_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_value_d = resp_value_q;

        tag_d[0].vld = any_gnt;
        tag_d[0].id  = LUT_ID_W_MAX'(gnt_id);
        for (int unsigned s = 1; s < PIPE_D; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        if (any_gnt) begin
            lut_op_d    = lut_op_e'(sel_op);
            lut_angle_d = sel_angle;
            rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end

        if (tag_q[PIPE_D-1].vld) begin
            resp_valid_d = 1'b1;
            resp_id_d    = tag_q[PIPE_D-1].id[ID_W-1:0];
            resp_value_d = lut_value;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lut_op_q     <= LUT_OP_0;
            lut_angle_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_value_q <= '0;
            for (int unsigned s = 0; s < PIPE_D; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lut_op_q     <= lut_op_d;
            lut_angle_q  <= lut_angle_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_value_q <= resp_value_d;
            for (int unsigned s = 0; s < PIPE_D; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Busy while any tag is in flight or a response is being presented.
    always_comb begin
        busy = resp_valid_q;
        for (int unsigned s = 0; s < PIPE_D; s++) begin
            busy = busy | tag_q[s].vld;
        end
    end

    // Tag ID is sized for 8 requesters; upper bits may go unread.
    assign unused_tag_id = ^tag_q[PIPE_D-1].id;

    assign req_ready       = gnt;
    assign lut_op_selector = lut_op_q;
    assign lut_angle       = lut_angle_q;
    assign resp_valid      = resp_valid_q;
    assign resp_id         = resp_id_q;
    assign resp_value      = resp_value_q;

`ifdef LUT_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Saturating handshake and contention counters.
    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (any_gnt && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
        if (($countones(req_valid) > 1) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule : lut_arbiter
